// File: rtl/nf10_xgmii_tx_encoder.sv
// ---------------------------------------------------------------------------
// nf10_xgmii_tx_encoder
//
// Transmit-side encoder for the 10G port. Takes egress packets from a 64-bit
// AXI4-Stream slave and produces a 64-bit XGMII transmit stream. It inserts
// the Start/preamble word, places Terminate after the last valid byte, fills
// idle between frames, and enforces a minimum inter-frame gap of C_IFG_WORDS
// all-idle words. Frames are forwarded verbatim (FCS is already in the stream).
//
// Handshake: a beat transfers on every rising edge where s_axis_tvalid and
// s_axis_tready are both high. tready is registered and depends only on the
// FSM state: high in DATA and DROP, low in IDLE, TERM and IFG. A master that
// lets tvalid fall in DATA has underrun the link. The frame is aborted with an
// Error word, and its remaining beats are drained in DROP.
//
// Parameters:
//   C_S_AXIS_DATA_WIDTH   stream data width (only 64 supported)
//   C_S_AXIS_TUSER_WIDTH  sideband width (ignored)
//   C_IFG_WORDS           idle words after each frame, minimum 1
//
// Ports:
//   axi_aclk        clock, also the XGMII transmit clock
//   axi_reset       synchronous active-high reset
//   s_axis_tdata    frame bytes, byte 0 in [7:0] goes first on the wire
//   s_axis_tstrb    byte enables, used on the last beat only
//   s_axis_tuser    ignored
//   s_axis_tvalid   beat valid
//   s_axis_tready   beat accepted when tvalid & tready
//   s_axis_tlast    final beat of the frame
//   xgmii_txd       XGMII data, lane k = bits [8k+7:8k]
//   xgmii_txc       XGMII per-lane control flags
//   tx_frame_count  frames terminated normally
//   tx_error_count  frames aborted on underrun
//
// Build option: define NF10_XGMII_TX_STATS_EN to build the two counters.
// Without it, both counter ports are tied to zero.
// ---------------------------------------------------------------------------
module nf10_xgmii_tx_encoder #(
    parameter int C_S_AXIS_DATA_WIDTH  = 64,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_IFG_WORDS          = 2
) (
    input  logic                                 axi_aclk,
    input  logic                                 axi_reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic                                 s_axis_tvalid,
    output logic                                 s_axis_tready,
    input  logic                                 s_axis_tlast,
    output logic [63:0]                          xgmii_txd,
    output logic [7:0]                           xgmii_txc,
    output logic [31:0]                          tx_frame_count,
    output logic [15:0]                          tx_error_count
);

    localparam logic [63:0] IDLE_WORD = 64'h0707070707070707;
    localparam logic [63:0] PRE_WORD  = 64'hD5555555555555FB;
    localparam logic [63:0] TERM_WORD = 64'h07070707070707FD;
    localparam logic [63:0] ERR_WORD  = 64'hFEFEFEFEFEFEFEFE;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_TERM = 3'd2,
        ST_DROP = 3'd3,
        ST_IFG  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] ifg_cnt;
    logic        ifg_done;
    logic [3:0]  last_bytes;
    logic [63:0] txd_nxt;
    logic [7:0]  txc_nxt;
    logic        tready_nxt;
    logic        unused_tuser;

    assign unused_tuser = ^s_axis_tuser;
    assign ifg_done     = (ifg_cnt == 16'(C_IFG_WORDS - 1));

    // The byte count is taken from the highest set strobe bit, not a popcount,
    // so a sparse strobe still places Terminate just above the top byte.
    always_comb begin
        last_bytes = 4'd0;
        for (int k = 0; k < 8; k++) begin
            if (s_axis_tstrb[k]) begin
                last_bytes = 4'(k + 1);
            end
        end
    end

    // State register. The outputs are registered here as well.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state         <= ST_IDLE;
            ifg_cnt       <= 16'd0;
            xgmii_txd     <= IDLE_WORD;
            xgmii_txc     <= 8'hFF;
            s_axis_tready <= 1'b0;
        end else begin
            state         <= state_nxt;
            ifg_cnt       <= (state == ST_IFG) ? ifg_cnt + 16'd1 : 16'd0;
            xgmii_txd     <= txd_nxt;
            xgmii_txc     <= txc_nxt;
            s_axis_tready <= tready_nxt;
        end
    end

    // Next-state logic. In DATA and DROP, tready is known to be high, so
    // tvalid alone marks an accepted beat.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (s_axis_tvalid) state_nxt = ST_DATA;
            ST_DATA: begin
                if (!s_axis_tvalid) begin
                    state_nxt = ST_DROP;
                end else if (s_axis_tlast) begin
                    state_nxt = (last_bytes == 4'd8) ? ST_TERM : ST_IFG;
                end
            end
            ST_TERM: state_nxt = ST_IFG;
            ST_DROP: if (s_axis_tvalid && s_axis_tlast) state_nxt = ST_IFG;
            ST_IFG:  if (ifg_done) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic. It computes the word and the tready value for the next
    // cycle.
    always_comb begin
        txd_nxt    = IDLE_WORD;
        txc_nxt    = 8'hFF;
        tready_nxt = (state_nxt == ST_DATA) || (state_nxt == ST_DROP);
        case (state)
            ST_IDLE: begin
                if (s_axis_tvalid) begin
                    txd_nxt = PRE_WORD;
                    txc_nxt = 8'h01;
                end
            end
            ST_DATA: begin
                if (!s_axis_tvalid) begin
                    txd_nxt = ERR_WORD;
                end else if (!s_axis_tlast || last_bytes == 4'd8) begin
                    txd_nxt = s_axis_tdata;
                    txc_nxt = 8'h00;
                end else begin
                    // Short last beat: data, then Terminate, then idle fill.
                    for (int k = 0; k < 8; k++) begin
                        if (4'(k) < last_bytes) begin
                            txd_nxt[8*k +: 8] = s_axis_tdata[8*k +: 8];
                            txc_nxt[k]        = 1'b0;
                        end else if (4'(k) == last_bytes) begin
                            txd_nxt[8*k +: 8] = 8'hFD;
                        end
                    end
                end
            end
            ST_TERM: txd_nxt = TERM_WORD;
            default: ;
        endcase
    end

`ifdef NF10_XGMII_TX_STATS_EN
    logic frame_done;
    logic frame_abort;

    assign frame_done  = (state == ST_DATA) && s_axis_tvalid && s_axis_tlast;
    assign frame_abort = (state == ST_DATA) && !s_axis_tvalid;

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            tx_frame_count <= 32'd0;
            tx_error_count <= 16'd0;
        end else begin
            if (frame_done)  tx_frame_count <= tx_frame_count + 32'd1;
            if (frame_abort) tx_error_count <= tx_error_count + 16'd1;
        end
    end
`else
    assign tx_frame_count = 32'd0;
    assign tx_error_count = 16'd0;
`endif

endmodule

// File: tb/tb_nf10_xgmii_tx_encoder.sv
// ---------------------------------------------------------------------------
// tb_nf10_xgmii_tx_encoder
//
// Testbench for nf10_xgmii_tx_encoder. Each driven cycle pushes the
// {tready, txc, txd} value that the encoder must present after that clock
// edge. A monitor pops and compares these values on the following falling
// edge. Each scenario task also checks the counters and reset values inline.
// Counter expectations follow NF10_XGMII_TX_STATS_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_nf10_xgmii_tx_encoder;

  localparam int          IFG    = 2;
  localparam logic [63:0] IDLE_W = 64'h0707070707070707;
  localparam logic [63:0] PRE_W  = 64'hD5555555555555FB;
  localparam logic [63:0] TERM_W = 64'h07070707070707FD;
  localparam logic [63:0] ERR_W  = 64'hFEFEFEFEFEFEFEFE;

  logic         axi_aclk;
  logic         axi_reset;
  logic [63:0]  s_axis_tdata;
  logic [7:0]   s_axis_tstrb;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [63:0]  xgmii_txd;
  logic [7:0]   xgmii_txc;
  logic [31:0]  tx_frame_count;
  logic [15:0]  tx_error_count;

  nf10_xgmii_tx_encoder #(
    .C_S_AXIS_DATA_WIDTH (64),
    .C_S_AXIS_TUSER_WIDTH(128),
    .C_IFG_WORDS         (IFG)
  ) dut (
    .axi_aclk      (axi_aclk),
    .axi_reset     (axi_reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .xgmii_txd     (xgmii_txd),
    .xgmii_txc     (xgmii_txc),
    .tx_frame_count(tx_frame_count),
    .tx_error_count(tx_error_count)
  );

  // ---------------- clock / reset ----------------
  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  int cyc_cnt = 0;
  always @(posedge axi_aclk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- scoreboard ----------------
  logic [72:0] exp_q[$];
  int          exp_cyc_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          exp_frames = 0;
  int          exp_errors = 0;
  logic [63:0] next_beat0;
  logic [72:0] mon_exp;
  int          mon_cyc;

  always @(negedge axi_aclk) begin
    if (exp_q.size() > 0 && exp_cyc_q[0] <= cyc_cnt) begin
      mon_exp = exp_q.pop_front();
      mon_cyc = exp_cyc_q.pop_front();
      n_checks++;
      if (mon_cyc != cyc_cnt)
        $display("FAIL wire_late: expected at cycle %0d, compared at cycle %0d", mon_cyc, cyc_cnt);
      else if ({s_axis_tready, xgmii_txc, xgmii_txd} !== mon_exp)
        $display("FAIL wire cycle %0d: got tready=%b txc=%h txd=%h, want tready=%b txc=%h txd=%h",
                 cyc_cnt, s_axis_tready, xgmii_txc, xgmii_txd,
                 mon_exp[72], mon_exp[71:64], mon_exp[63:0]);
      else
        n_pass++;
    end
  end

  // Expected word for a last beat, derived from the highest set strobe bit.
  function automatic logic [72:0] last_exp(input logic [63:0] d, input logic [7:0] s);
    int          n;
    logic [63:0] w;
    logic [7:0]  c;
    n = 0;
    for (int k = 0; k < 8; k++) if (s[k]) n = k + 1;
    if (n == 8) return {1'b0, 8'h00, d};
    for (int k = 0; k < 8; k++) begin
      if (k < n) begin
        w[8*k +: 8] = d[8*k +: 8];
        c[k] = 1'b0;
      end else begin
        w[8*k +: 8] = (k == n) ? 8'hFD : 8'h07;
        c[k] = 1'b1;
      end
    end
    return {1'b0, c, w};
  endfunction

  // ---------------- driver tasks ----------------
  // Drives inputs for one cycle. e is the value expected after the edge.
  task automatic cyc(input logic v, input logic last, input logic [63:0] d,
                     input logic [7:0] s, input logic [72:0] e);
    s_axis_tvalid = v;
    s_axis_tlast  = last;
    s_axis_tdata  = d;
    s_axis_tstrb  = s;
    s_axis_tuser  = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp_q.push_back(e);
    exp_cyc_q.push_back(cyc_cnt + 1);
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 64'd0, 8'd0, {1'b0, 8'hFF, IDLE_W});
  endtask

  // Drives a full frame from the IDLE cycle through the end of IFG. With
  // hold_next set, tvalid stays high during TERM/IFG, presenting the next
  // frame's first beat.
  task automatic drive_frame(input int nbeats, input logic [7:0] last_strb, input logic hold_next);
    logic [63:0] d;
    d = next_beat0;
    cyc(1'b1, 1'b0, d, 8'hFF, {1'b1, 8'h01, PRE_W});
    for (int i = 0; i < nbeats; i++) begin
      if (i > 0) d = {$urandom(), $urandom()};
      if (i == nbeats - 1)
        cyc(1'b1, 1'b1, d, last_strb, last_exp(d, last_strb));
      else
        cyc(1'b1, 1'b0, d, 8'($urandom_range(0, 255)), {1'b1, 8'h00, d});
    end
    next_beat0 = {$urandom(), $urandom()};
    if (last_strb[7])
      cyc(hold_next, 1'b0, next_beat0, 8'hFF, {1'b0, 8'hFF, TERM_W});
    for (int i = 0; i < IFG; i++)
      cyc(hold_next, 1'b0, next_beat0, 8'hFF, {1'b0, 8'hFF, IDLE_W});
`ifdef NF10_XGMII_TX_STATS_EN
    exp_frames++;
`endif
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(negedge axi_aclk);
      #1;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL %s_drain: %0d expected words left, want 0", name, exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
    @(posedge axi_aclk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    axi_reset = 1'b1;
    cyc(1'b1, 1'b0, 64'h1122334455667788, 8'hFF, {1'b0, 8'hFF, IDLE_W});
    cyc(1'b1, 1'b0, 64'h1122334455667788, 8'hFF, {1'b0, 8'hFF, IDLE_W});
    n_checks++;
    if (xgmii_txd !== IDLE_W) $display("FAIL reset_txd: got %h want %h", xgmii_txd, IDLE_W);
    else n_pass++;
    n_checks++;
    if (xgmii_txc !== 8'hFF) $display("FAIL reset_txc: got %h want ff", xgmii_txc);
    else n_pass++;
    n_checks++;
    if (s_axis_tready !== 1'b0) $display("FAIL reset_tready: got %b want 0", s_axis_tready);
    else n_pass++;
    n_checks++;
    if (tx_frame_count !== 32'd0) $display("FAIL reset_frames: got %0d want 0", tx_frame_count);
    else n_pass++;
    n_checks++;
    if (tx_error_count !== 16'd0) $display("FAIL reset_errors: got %0d want 0", tx_error_count);
    else n_pass++;
    axi_reset = 1'b0;
    idle_cycles(2);
    wait_drain("reset");
  endtask

  task automatic test_counters(input string name);
    n_checks++;
    if (tx_frame_count !== 32'(exp_frames))
      $display("FAIL %s_frames: got %0d want %0d", name, tx_frame_count, exp_frames);
    else n_pass++;
    n_checks++;
    if (tx_error_count !== 16'(exp_errors))
      $display("FAIL %s_errors: got %0d want %0d", name, tx_error_count, exp_errors);
    else n_pass++;
  endtask

  task automatic test_full_frame;
    drive_frame(8, 8'hFF, 1'b0);
    idle_cycles(1);
    wait_drain("full_frame");
    test_counters("full_frame");
  endtask

  task automatic test_short_frame;
    logic [7:0] strbs[6];
    strbs = '{8'h0F, 8'h01, 8'h05, 8'h7F, 8'h80, 8'h3C};
    drive_frame(8, strbs[0], 1'b0);
    idle_cycles(1);
    for (int i = 1; i < 6; i++) begin
      drive_frame(2, strbs[i], 1'b0);
      idle_cycles(1);
    end
    wait_drain("short_frame");
    test_counters("short_frame");
  endtask

  task automatic test_strb_zero;
    drive_frame(2, 8'h00, 1'b0);
    idle_cycles(1);
    wait_drain("strb_zero");
    test_counters("strb_zero");
  endtask

  task automatic test_back_to_back;
    drive_frame(3, 8'hFF, 1'b1);
    drive_frame(4, 8'h07, 1'b1);
    drive_frame(2, 8'h01, 1'b0);
    idle_cycles(1);
    wait_drain("back_to_back");
    test_counters("back_to_back");
  endtask

  task automatic test_underrun;
    logic [63:0] d;
    d = next_beat0;
    cyc(1'b1, 1'b0, d, 8'hFF, {1'b1, 8'h01, PRE_W});
    for (int i = 0; i < 3; i++) begin
      if (i > 0) d = {$urandom(), $urandom()};
      cyc(1'b1, 1'b0, d, 8'($urandom_range(0, 255)), {1'b1, 8'h00, d});
    end
    cyc(1'b0, 1'b0, 64'd0, 8'd0, {1'b1, 8'hFF, ERR_W});
    cyc(1'b0, 1'b0, 64'd0, 8'd0, {1'b1, 8'hFF, IDLE_W});
    for (int i = 3; i < 8; i++)
      cyc(1'b1, i == 7, {$urandom(), $urandom()}, 8'hFF, {(i != 7), 8'hFF, IDLE_W});
    idle_cycles(IFG + 1);
`ifdef NF10_XGMII_TX_STATS_EN
    exp_errors++;
`endif
    next_beat0 = {$urandom(), $urandom()};
    wait_drain("underrun");
    test_counters("underrun");
  endtask

  task automatic test_reset_mid_frame;
    logic [63:0] d;
    d = next_beat0;
    cyc(1'b1, 1'b0, d, 8'hFF, {1'b1, 8'h01, PRE_W});
    for (int i = 0; i < 4; i++) begin
      if (i > 0) d = {$urandom(), $urandom()};
      cyc(1'b1, 1'b0, d, 8'hFF, {1'b1, 8'h00, d});
    end
    axi_reset = 1'b1;
    cyc(1'b1, 1'b0, {$urandom(), $urandom()}, 8'hFF, {1'b0, 8'hFF, IDLE_W});
    axi_reset = 1'b0;
    exp_frames = 0;
    exp_errors = 0;
    test_counters("reset_mid");
    idle_cycles(1);
    next_beat0 = {$urandom(), $urandom()};
    drive_frame(5, 8'h3F, 1'b0);
    idle_cycles(1);
    wait_drain("reset_mid_after");
    test_counters("reset_mid_after");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    axi_reset     = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = 64'd0;
    s_axis_tstrb  = 8'd0;
    s_axis_tuser  = 128'd0;
    next_beat0    = {$urandom(), $urandom()};
    @(posedge axi_aclk);
    #1;
    test_reset();
    test_full_frame();
    test_short_frame();
    test_strb_zero();
    test_back_to_back();
    test_underrun();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
